fas_frame_sched: RTL and testbench

FAS_FRAME_SCHED -- requirements
Module: fas_frame_sched

---
 rtl/fas_pkg.sv | 7 +
 rtl/fas_frame_bank.sv | 25 ++
 rtl/fas_frame_sched.sv | 90 +++++++++
 tb/tb_fas_frame_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// fas_pkg: shared constants and FSM encoding for the FFT frame scheduler
package fas_pkg;
  localparam int FAS_N_PT = 16;
  localparam int FAS_N_FRAMES = 64;
  localparam int FAS_SW = 16;
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
endpackage

// File: rtl/fas_frame_bank.sv
// fas_frame_bank: one N_PT-sample ping-pong bank with full flag and parallel read bus
module fas_frame_bank import fas_pkg::*; #(
  parameter int N_PT = FAS_N_PT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [$clog2(N_PT)-1:0]   waddr_i,
  input  logic [FAS_SW-1:0]         wdata_i,
  input  logic                      set_full_i,
  input  logic                      clr_full_i,
  output logic                      full_o,
  output logic [FAS_SW*N_PT-1:0]    rdata_o
);
  logic [N_PT-1:0][FAS_SW-1:0] mem_q;
  logic full_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (!rst) full_q <= 1'b0;
    else if (set_full_i) full_q <= 1'b1;
    else if (clr_full_i) full_q <= 1'b0;
  end
  assign full_o = full_q;
  assign rdata_o = mem_q;
endmodule

// File: rtl/fas_frame_sched.sv
// fas_frame_sched: ping-pong frame buffer feeding FIR samples to an FFT engine
module fas_frame_sched import fas_pkg::*; #(
  parameter int N_PT = FAS_N_PT,
  parameter int N_FRAMES = FAS_N_FRAMES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fir_valid,
  input  logic [FAS_SW-1:0]        fir_d,
  input  logic                     fft_busy,
  input  logic                     fft_done,
  output logic                     fft_start,
  output logic [FAS_SW*N_PT-1:0]   frame_data,
  output logic [5:0]               frame_idx,
  output logic                     overflow,
  output logic                     all_done
);
  localparam int AW = $clog2(N_PT);
  localparam logic [AW-1:0] LAST = AW'(N_PT - 1);
  localparam logic [5:0] IDX_LAST = 6'(N_FRAMES - 1);
  state_t state_q;
  logic [AW-1:0] wptr_q;
  logic wbank_q, rbank_q, fft_start_q, overflow_q, all_done_q;
  logic [5:0] frame_idx_q;
  logic [1:0] full, we, set_full, clr_full;
  logic [1:0][FAS_SW*N_PT-1:0] rdata;
  logic rel, wr_full, wr_ok, last_wr, rd_ready;
  // a release of the write bank in the same cycle frees it for this sample
  always_comb begin
    rel = state_q == WAIT && fft_done;
    wr_full = full[wbank_q] && !(rel && rbank_q == wbank_q);
    wr_ok = fir_valid && !all_done_q && !wr_full;
    last_wr = wr_ok && wptr_q == LAST;
    rd_ready = full[rbank_q] || (last_wr && wbank_q == rbank_q);
    we = wr_ok ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;
    set_full = last_wr ? we : 2'b00;
    clr_full = rel ? (rbank_q ? 2'b10 : 2'b01) : 2'b00;
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fas_frame_bank #(.N_PT(N_PT)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .we_i       (we[b]),
      .waddr_i    (wptr_q),
      .wdata_i    (fir_d),
      .set_full_i (set_full[b]),
      .clr_full_i (clr_full[b]),
      .full_o     (full[b]),
      .rdata_o    (rdata[b])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr_q <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      fft_start_q <= 1'b0;
      frame_idx_q <= '0;
      overflow_q <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= last_wr ? '0 : wptr_q + 1'b1;
      if (last_wr) wbank_q <= !wbank_q;
      if (fir_valid && !all_done_q && wr_full) overflow_q <= 1'b1;
      if (rel) begin
        rbank_q <= !rbank_q;
        frame_idx_q <= frame_idx_q == IDX_LAST ? frame_idx_q : frame_idx_q + 1'b1;
        if (frame_idx_q == IDX_LAST) all_done_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (rd_ready && !fft_busy) begin
          state_q <= START;
          fft_start_q <= 1'b1;
        end
        START: begin
          state_q <= WAIT;
          fft_start_q <= 1'b0;
        end
        WAIT: if (fft_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign fft_start = fft_start_q;
  assign frame_data = rdata[rbank_q];
  assign frame_idx = frame_idx_q;
  assign overflow = overflow_q;
  assign all_done = all_done_q;
endmodule

// File: tb/tb_fas_frame_sched.sv
// tb_fas_frame_sched: directed self-checking bench for fas_frame_sched
module tb_fas_frame_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fir_valid = 1'b0;
  logic [15:0] fir_d = '0;
  logic fft_busy = 1'b0;
  logic fft_done_man = 1'b0;
  logic fft_done_auto = 1'b0;
  logic auto_en = 1'b0;
  logic fft_done;
  logic fft_start, overflow, all_done;
  logic [255:0] frame_data;
  logic [5:0] frame_idx;
  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;
  int auto_cnt = 0;
  int base;

  assign fft_done = fft_done_man | fft_done_auto;

  fas_frame_sched dut (
    .clk        (clk),
    .rst        (rst),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d),
    .fft_busy   (fft_busy),
    .fft_done   (fft_done),
    .fft_start  (fft_start),
    .frame_data (frame_data),
    .frame_idx  (frame_idx),
    .overflow   (overflow),
    .all_done   (all_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fft_start) n_start++;

  // FFT engine model: fft_done pulses 20 cycles after each fft_start
  always @(negedge clk) begin
    fft_done_auto = 1'b0;
    if (!auto_en) auto_cnt = 0;
    else if (fft_start) auto_cnt = 20;
    else if (auto_cnt != 0) begin
      auto_cnt--;
      if (auto_cnt == 0) fft_done_auto = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v);
    fir_valid = 1'b1;
    fir_d = v;
    tick();
    fir_valid = 1'b0;
  endtask

  task automatic done_pulse();
    fft_done_man = 1'b1;
    tick();
    fft_done_man = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fir_valid = 1'b0;
    fft_busy = 1'b0;
    fft_done_man = 1'b0;
    auto_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_start", 16'(fft_start), 0);
    chk("rst_idx", 16'(frame_idx), 0);
    chk("rst_ovf", 16'(overflow), 0);
    chk("rst_alldone", 16'(all_done), 0);

    // single frame, start one cycle after the 16th capture
    base = n_start;
    for (int i = 1; i <= 16; i++) push(16'(i));
    chk("f0_start", 16'(fft_start), 1);
    chk("f0_lo", frame_data[15:0], 16'h0001);
    chk("f0_hi", frame_data[255:240], 16'h0010);
    chk("f0_idx", 16'(frame_idx), 0);
    tick();
    chk("f0_pulse", 16'(fft_start), 0);
    chk("f0_count", 16'(n_start - base), 1);

    // 32 contiguous samples, fft_done coincides with the 32nd
    do_reset();
    for (int i = 1; i <= 31; i++) push(16'(i));
    fft_done_man = 1'b1;
    push(16'd32);
    fft_done_man = 1'b0;
    chk("c32_ovf", 16'(overflow), 0);
    chk("c32_gap1", 16'(fft_start), 0);
    tick();
    chk("c32_start", 16'(fft_start), 1);
    chk("c32_idx", 16'(frame_idx), 1);
    chk("c32_lo", frame_data[15:0], 16'h0011);
    chk("c32_hi", frame_data[255:240], 16'h0020);

    // 48 samples, no fft_done: last 16 dropped, frame 0 held intact
    do_reset();
    for (int i = 1; i <= 48; i++) push(16'(i));
    chk("o48_ovf", 16'(overflow), 1);
    chk("o48_hold_lo", frame_data[15:0], 16'h0001);
    chk("o48_hold_hi", frame_data[255:240], 16'h0010);
    done_pulse();
    tick();
    chk("o48_start", 16'(fft_start), 1);
    chk("o48_idx", 16'(frame_idx), 1);
    chk("o48_lo", frame_data[15:0], 16'h0011);
    chk("o48_hi", frame_data[255:240], 16'h0020);

    // sample write and release of the same bank in one cycle
    do_reset();
    for (int i = 1; i <= 32; i++) push(16'(i));
    fft_done_man = 1'b1;
    push(16'h0100);
    fft_done_man = 1'b0;
    chk("same_ovf", 16'(overflow), 0);
    for (int i = 1; i <= 15; i++) push(16'h0100 + 16'(i));
    chk("same_idx1", 16'(frame_idx), 1);
    chk("same_ovf2", 16'(overflow), 0);
    done_pulse();
    tick();
    chk("same_start", 16'(fft_start), 1);
    chk("same_idx2", 16'(frame_idx), 2);
    chk("same_lo", frame_data[15:0], 16'h0100);
    chk("same_hi", frame_data[255:240], 16'h010F);

    // full run of 64 frames with a 20-cycle FFT
    do_reset();
    auto_en = 1'b1;
    base = n_start;
    for (int i = 0; i < 1024; i++) begin
      push(16'(i));
      tick();
    end
    for (int i = 0; i < 100 && !all_done; i++) tick();
    chk("run_alldone", 16'(all_done), 1);
    chk("run_starts", 16'(n_start - base), 64);
    chk("run_ovf", 16'(overflow), 0);
    chk("run_idx", 16'(frame_idx), 63);
    for (int i = 0; i < 16; i++) push(16'hBEEF);
    tick();
    tick();
    chk("run_ignore", 16'(n_start - base), 64);
    chk("run_ovf2", 16'(overflow), 0);

    // reset mid-frame 3
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      push(16'(i));
      tick();
    end
    for (int i = 0; i < 40; i++) tick();
    chk("mid_idx3", 16'(frame_idx), 3);
    for (int i = 0; i < 10; i++) push(16'h5000 + 16'(i));
    auto_en = 1'b0;
    rst = 1'b0;
    tick();
    chk("mid_rst_start", 16'(fft_start), 0);
    chk("mid_rst_idx", 16'(frame_idx), 0);
    chk("mid_rst_ovf", 16'(overflow), 0);
    chk("mid_rst_alldone", 16'(all_done), 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) push(16'hA000 + 16'(i));
    chk("mid_start", 16'(fft_start), 1);
    chk("mid_idx", 16'(frame_idx), 0);
    chk("mid_lo", frame_data[15:0], 16'hA000);
    chk("mid_hi", frame_data[255:240], 16'hA00F);

    // fft_busy holds off the start for 5 cycles
    do_reset();
    fft_busy = 1'b1;
    for (int i = 1; i <= 16; i++) push(16'(i));
    for (int i = 0; i < 5; i++) begin
      chk("busy_hold", 16'(fft_start), 0);
      if (i < 4) tick();
    end
    fft_busy = 1'b0;
    tick();
    chk("busy_start", 16'(fft_start), 1);
    chk("busy_lo", frame_data[15:0], 16'h0001);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
